// File: rtl/wavegen_dac_spi.sv
// Dual-channel SPI DAC driver for wavegen sample pairs.
// Sends A then B frames, then pulses LDAC; flags overrun.
module wavegen_dac_spi #(
  parameter int         CLK_DIV    = 4,
  parameter logic [7:0] CMD_A      = 8'h18,
  parameter logic [7:0] CMD_B      = 8'h19,
  parameter int         LDAC_WIDTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        sample_stb,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        clr_overrun,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] sample_count,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_mosi,
  output logic        dac_ldac_n
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_A,
    GAP_A,
    SHIFT_B,
    GAP_B,
    LDAC
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] LDAC_LAST = 16'(LDAC_WIDTH - 1);

  state_t      state;
  logic [15:0] div_cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] sr;
  logic [15:0] code_b;
  logic        accept;
  logic        drop;

  assign accept = sample_stb && en && (state == IDLE);
  assign drop   = sample_stb && en && (state != IDLE);

  // Frame sequencer: shifts both frames, then loads the DAC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      sr           <= '0;
      code_b       <= '0;
      busy         <= 1'b0;
      sample_count <= '0;
      dac_sclk     <= 1'b1;
      dac_sync_n   <= 1'b1;
      dac_mosi     <= 1'b0;
      dac_ldac_n   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sr         <= {CMD_A, ~in_a[15], in_a[14:0]};
            code_b     <= {~in_b[15], in_b[14:0]};
            dac_mosi   <= CMD_A[7];
            dac_sclk   <= 1'b1;
            dac_sync_n <= 1'b0;
            busy       <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            state      <= SHIFT_A;
          end
        end
        SHIFT_A, SHIFT_B: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt <= '0;
            if (dac_sclk) begin
              dac_sclk <= 1'b0;
            end else if (bit_cnt == 5'd23) begin
              dac_sclk   <= 1'b1;
              dac_sync_n <= 1'b1;
              dac_mosi   <= 1'b0;
              state <= (state == SHIFT_A) ? GAP_A : GAP_B;
            end else begin
              bit_cnt  <= bit_cnt + 5'd1;
              dac_sclk <= 1'b1;
              dac_mosi <= sr[22];
              sr       <= {sr[22:0], 1'b0};
            end
          end
        end
        GAP_A: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sr         <= {CMD_B, code_b};
            dac_mosi   <= CMD_B[7];
            dac_sync_n <= 1'b0;
            state      <= SHIFT_B;
          end
        end
        GAP_B: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt    <= '0;
            dac_ldac_n <= 1'b0;
            state      <= LDAC;
          end
        end
        LDAC: begin
          if (div_cnt != LDAC_LAST) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt      <= '0;
            dac_ldac_n   <= 1'b1;
            busy         <= 1'b0;
            sample_count <= sample_count + 16'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overrun; a new drop beats a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wavegen_dac_spi.sv
// Bench for wavegen_dac_spi: SPI frame scoreboard,
// busy/LDAC timing, overrun, enable, reset and wrap.
module tb_wavegen_dac_spi;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic        sample_stb;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        clr_overrun;
  logic        busy;
  logic        overrun;
  logic [15:0] sample_count;
  logic        dac_sclk;
  logic        dac_sync_n;
  logic        dac_mosi;
  logic        dac_ldac_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_q[$];

  wavegen_dac_spi dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .sample_stb(sample_stb),
    .in_a(in_a),
    .in_b(in_b),
    .clr_overrun(clr_overrun),
    .busy(busy),
    .overrun(overrun),
    .sample_count(sample_count),
    .dac_sclk(dac_sclk),
    .dac_sync_n(dac_sync_n),
    .dac_mosi(dac_mosi),
    .dac_ldac_n(dac_ldac_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // SPI monitor plus busy/LDAC pulse-width checks
  logic [23:0] fr = '0;
  int nbits = 0;
  int bcnt = 0;
  int lcnt = 0;
  int sync_falls = 0;
  logic p_sclk = 1'b1;
  logic p_sync = 1'b1;
  logic p_busy = 1'b0;
  logic p_ldac = 1'b1;

  always @(negedge clk) begin
    if (!resetn) begin
      nbits = 0;
      bcnt  = 0;
      lcnt  = 0;
    end else begin
      if (p_sync && !dac_sync_n) begin
        sync_falls++;
        nbits = 0;
      end
      if (!dac_sync_n && p_sclk && !dac_sclk) begin
        fr = {fr[22:0], dac_mosi};
        nbits++;
      end
      if (!p_sync && dac_sync_n) begin
        chk("frame_bits", 32'(nbits), 32'd24);
        if (exp_q.size() == 0)
          chk("frame_extra", {8'h0, fr}, 32'hFFFF_FFFF);
        else
          chk("frame", {8'h0, fr}, {8'h0, exp_q.pop_front()});
      end
      if (busy) begin
        bcnt++;
      end else if (p_busy) begin
        chk("busy_len", 32'(bcnt), 32'd394);
        bcnt = 0;
      end
      if (!dac_ldac_n) begin
        lcnt++;
      end else if (!p_ldac) begin
        chk("ldac_len", 32'(lcnt), 32'd2);
        lcnt = 0;
      end
    end
    p_sclk = dac_sclk;
    p_sync = dac_sync_n;
    p_busy = busy;
    p_ldac = dac_ldac_n;
  end

  task automatic push_pair(input logic [15:0] a,
                           input logic [15:0] b);
    exp_q.push_back({8'h18, a ^ 16'h8000});
    exp_q.push_back({8'h19, b ^ 16'h8000});
  endtask

  task automatic strobe(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic e,
                        input bit push);
    @(posedge clk);
    #1;
    en = e;
    in_a = a;
    in_b = b;
    sample_stb = 1'b1;
    if (push) push_pair(a, b);
    @(posedge clk);
    #1;
    sample_stb = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n >= 3000), 32'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
  endtask

  int sf;

  initial begin
    resetn = 1'b0;
    en = 1'b0;
    sample_stb = 1'b0;
    in_a = '0;
    in_b = '0;
    clr_overrun = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(dac_sclk), 32'd1);
    chk("rst_sync", 32'(dac_sync_n), 32'd1);
    chk("rst_mosi", 32'(dac_mosi), 32'd0);
    chk("rst_ldac", 32'(dac_ldac_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_cnt", 32'(sample_count), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // basic pair
    strobe(16'h0000, 16'h8000, 1'b1, 1'b1);
    chk("busy_rise", 32'(busy), 32'd1);
    wait_idle();
    chk("cnt1", 32'(sample_count), 32'd1);
    chk("ovr1", 32'(overrun), 32'd0);

    // overrun: second strobe is dropped
    strobe(16'h7FFF, 16'hFFFF, 1'b1, 1'b1);
    repeat (100) @(posedge clk);
    strobe(16'h1234, 16'h5678, 1'b1, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    pulse_clr();
    chk("ovr_clr", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    sample_stb = 1'b1;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    sample_stb = 1'b0;
    clr_overrun = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    wait_idle();
    chk("cnt2", 32'(sample_count), 32'd2);

    // en low: strobe ignored
    pulse_clr();
    sf = sync_falls;
    strobe(16'h4321, 16'h1111, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    chk("en0_sync", 32'(sync_falls), 32'(sf));
    chk("en0_busy", 32'(busy), 32'd0);
    chk("en0_ovr", 32'(overrun), 32'd0);

    // en dropped mid-transfer: pair completes
    strobe(16'hA5A5, 16'h0001, 1'b1, 1'b1);
    repeat (50) @(posedge clk);
    #1 en = 1'b0;
    wait_idle();
    en = 1'b1;
    chk("cnt3", 32'(sample_count), 32'd3);

    // reset mid SHIFT_A
    strobe(16'h3333, 16'h4444, 1'b1, 1'b0);
    repeat (30) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("mrst_sync", 32'(dac_sync_n), 32'd1);
    chk("mrst_sclk", 32'(dac_sclk), 32'd1);
    chk("mrst_mosi", 32'(dac_mosi), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_cnt", 32'(sample_count), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    strobe(16'hFEDC, 16'h0123, 1'b1, 1'b1);
    wait_idle();
    chk("cnt_after_rst", 32'(sample_count), 32'd1);

    // back-to-back: strobe in first idle cycle
    strobe(16'h0F0F, 16'hF0F0, 1'b1, 1'b1);
    wait_idle();
    sample_stb = 1'b1;
    in_a = 16'h5A5A;
    in_b = 16'hC3C3;
    push_pair(16'h5A5A, 16'hC3C3);
    @(posedge clk);
    #1 sample_stb = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_idle();
    chk("b2b_ovr", 32'(overrun), 32'd0);
    chk("cnt_b2b", 32'(sample_count), 32'd3);

    // count wrap from 0xFFFF
    @(negedge clk);
    force dut.sample_count = 16'hFFFF;
    @(negedge clk);
    release dut.sample_count;
    strobe(16'h8001, 16'h7FFE, 1'b1, 1'b1);
    wait_idle();
    chk("cnt_wrap", 32'(sample_count), 32'd0);

    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
